// File: rtl/stream_fc_pkg.sv
// rtl/stream_fc_pkg.sv - packet layout, config slice and credit helpers for the credit-based egress
package stream_fc_pkg;

  // Packet layout, MSB first: {vld, leaf, port, payload}.
  function automatic int packet_bits(int leaf_bits, int port_bits, int payload_bits);
    return 1 + leaf_bits + port_bits + payload_bits;
  endfunction

  function automatic int pkt_vld_bit(int leaf_bits, int port_bits, int payload_bits);
    return packet_bits(leaf_bits, port_bits, payload_bits) - 1;
  endfunction

  function automatic int pkt_leaf_lsb(int port_bits, int payload_bits);
    return port_bits + payload_bits;
  endfunction

  function automatic int pkt_port_lsb(int payload_bits);
    return payload_bits;
  endfunction

  // Per-channel config slice: {en, dest_leaf, dest_port}.
  function automatic int cfg_bits(int leaf_bits, int port_bits);
    return 1 + leaf_bits + port_bits;
  endfunction

  // Grant can only happen at credit >= 1, so the sum never goes negative.
  function automatic int credit_next(int credit, bit grant, bit ret, int update, int max_credit);
    int v;
    v = credit - (grant ? 1 : 0) + (ret ? update : 0);
    return (v > max_credit) ? max_credit : v;
  endfunction

endpackage

// File: rtl/sfc_chan_fifo.sv
// rtl/sfc_chan_fifo.sv - per-channel payload FIFO with registered count and full/empty flags
module sfc_chan_fifo #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d, avail_q, avail_d;
  logic                 push_q, push_d;
  logic                 do_push, do_pop;

  // count_q gates writes; avail_q trails pushes by one cycle so a word becomes
  // readable the cycle after it is written.
  assign full    = count_q[ADDR_BITS];
  assign empty   = (avail_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    avail_d  = avail_q;
    push_d   = do_push;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push & ~do_pop)      count_d = count_q + CNT_ONE;
    else if (~do_push & do_pop) count_d = count_q - CNT_ONE;
    if (push_q & ~do_pop)       avail_d = avail_q + CNT_ONE;
    else if (~push_q & do_pop)  avail_d = avail_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= '0;
      push_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      avail_q  <= avail_d;
      push_q   <= push_d;
    end
  end

endmodule

// File: rtl/stream_credit_out_arbiter.sv
// rtl/stream_credit_out_arbiter.sv - N-channel credit-gated round-robin merge onto one registered stream
// Optional STREAM_RESEND_EN adds a shadow of the last granted packet for re-emission.
module stream_credit_out_arbiter
  import stream_fc_pkg::*;
#(
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int PAYLOAD_BITS          = 64,
  parameter int NUM_CHANNELS          = 7,
  parameter int FIFO_ADDR_BITS        = 3,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [NUM_CHANNELS*(1+NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] cfg_reg,
  input  logic [NUM_CHANNELS*PAYLOAD_BITS-1:0]                  din_user,
  input  logic [NUM_CHANNELS-1:0]                               vld_user,
  output logic [NUM_CHANNELS-1:0]                               ack_user,
  input  logic [NUM_CHANNELS-1:0]                               credit_return,
  input  logic                                                  stream_rdy,
  output logic [NUM_LEAF_BITS+NUM_PORT_BITS+PAYLOAD_BITS:0]     stream_out,
  input  logic                                                  resend
);
  localparam int PKT_BITS   = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
  localparam int VLD        = pkt_vld_bit(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
  localparam int LEAF_LSB   = pkt_leaf_lsb(NUM_PORT_BITS, PAYLOAD_BITS);
  localparam int PORT_LSB   = pkt_port_lsb(PAYLOAD_BITS);
  localparam int CFGW       = cfg_bits(NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int CW         = NUM_BRAM_ADDR_BITS + 1;
  localparam int MAX_CREDIT = 1 << NUM_BRAM_ADDR_BITS;
  localparam int RRW        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0][PAYLOAD_BITS-1:0] fifo_data;
  logic [NUM_CHANNELS-1:0][PKT_BITS-1:0]     pkt_a;
  logic [NUM_CHANNELS-1:0][CW-1:0]           credit_q, credit_d;
  logic [NUM_CHANNELS-1:0] fifo_full, fifo_empty, chan_en, eligible, grant_vec, pop_vec;
  logic [PKT_BITS-1:0]     stream_out_q, stream_out_d, grant_pkt, shadow_pkt;
  logic [RRW-1:0]          rr_q, rr_d, rr_nxt;
  logic                    run_q, run_d, slot_free, arb_found, resend_fire;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    sfc_chan_fifo #(.WIDTH(PAYLOAD_BITS), .ADDR_BITS(FIFO_ADDR_BITS)) u_fifo (
      .clk    (clk),
      .rst_n  (reset),
      .push   (vld_user[g] & ack_user[g]),
      .pop    (pop_vec[g]),
      .wr_data(din_user[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_data(fifo_data[g]),
      .full   (fifo_full[g]),
      .empty  (fifo_empty[g])
    );
    assign chan_en[g]                           = cfg_reg[g*CFGW + CFGW - 1];
    assign pkt_a[g][VLD]                        = 1'b1;
    assign pkt_a[g][LEAF_LSB +: NUM_LEAF_BITS]  = cfg_reg[g*CFGW + NUM_PORT_BITS +: NUM_LEAF_BITS];
    assign pkt_a[g][PORT_LSB +: NUM_PORT_BITS]  = cfg_reg[g*CFGW +: NUM_PORT_BITS];
    assign pkt_a[g][PAYLOAD_BITS-1:0]           = fifo_data[g];
    assign eligible[g] = chan_en[g] & ~fifo_empty[g] & (credit_q[g] != '0);
  end

  assign ack_user   = ~fifo_full & {NUM_CHANNELS{run_q}};
  assign slot_free  = ~stream_out_q[VLD] | stream_rdy;
  assign stream_out = stream_out_q;
  assign run_d      = 1'b1;

  // Two passes give "lowest eligible index at or above rr_q, else wrap to the lowest".
  always_comb begin
    grant_vec = '0;
    grant_pkt = '0;
    arb_found = 1'b0;
    rr_nxt    = rr_q;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (!arb_found && eligible[j] && (RRW'(j) >= rr_q)) begin
        arb_found    = 1'b1;
        grant_vec[j] = 1'b1;
        grant_pkt    = pkt_a[j];
        rr_nxt       = (j == NUM_CHANNELS - 1) ? '0 : RRW'(j + 1);
      end
    end
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (!arb_found && eligible[j]) begin
        arb_found    = 1'b1;
        grant_vec[j] = 1'b1;
        grant_pkt    = pkt_a[j];
        rr_nxt       = (j == NUM_CHANNELS - 1) ? '0 : RRW'(j + 1);
      end
    end
  end

  always_comb begin
    stream_out_d = stream_out_q;
    pop_vec      = '0;
    rr_d         = rr_q;
    if (slot_free) begin
      if (resend_fire) begin
        stream_out_d = shadow_pkt;
      end else if (arb_found) begin
        stream_out_d = grant_pkt;
        pop_vec      = grant_vec;
        rr_d         = rr_nxt;
      end else begin
        stream_out_d[VLD] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      credit_d[j] = CW'(credit_next(int'(credit_q[j]), pop_vec[j], credit_return[j],
                                    FREESPACE_UPDATE_SIZE, MAX_CREDIT));
    end
  end

`ifdef STREAM_RESEND_EN
  logic [PKT_BITS-1:0] shadow_q, shadow_d;
  logic                shadow_vld_q, shadow_vld_d, pend_q, pend_d, resend_req;

  // A resend against an empty shadow is dropped rather than held pending.
  assign resend_req  = resend | pend_q;
  assign resend_fire = slot_free & resend_req & shadow_vld_q;
  assign shadow_pkt  = shadow_q;

  always_comb begin
    pend_d       = resend_req & ~slot_free & shadow_vld_q;
    shadow_d     = (|pop_vec) ? grant_pkt : shadow_q;
    shadow_vld_d = shadow_vld_q | (|pop_vec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      pend_q       <= pend_d;
    end
  end
`else
  logic unused_resend;
  assign unused_resend = resend;
  assign resend_fire   = 1'b0;
  assign shadow_pkt    = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stream_out_q <= '0;
      rr_q         <= '0;
      run_q        <= 1'b0;
      for (int j = 0; j < NUM_CHANNELS; j++) credit_q[j] <= CW'(MAX_CREDIT);
    end else begin
      stream_out_q <= stream_out_d;
      rr_q         <= rr_d;
      run_q        <= run_d;
      credit_q     <= credit_d;
    end
  end

endmodule

// File: tb/tb_stream_credit_out_arbiter.sv
// tb/tb_stream_credit_out_arbiter.sv - directed scoreboard bench for stream_credit_out_arbiter
module tb_stream_credit_out_arbiter;
  localparam int L = 6, P = 4, D = 64, N = 7;
  localparam int PB = 1 + L + P + D;
  localparam int CFGW = 1 + L + P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N*CFGW-1:0] cfg_reg;
  logic [N*D-1:0]    din_user;
  logic [N-1:0]      vld_user, ack_user, credit_return;
  logic              stream_rdy, resend;
  logic [PB-1:0]     stream_out;

  int n_checks = 0;
  int n_fails  = 0;
  logic [PB-1:0] sb[$];

  stream_credit_out_arbiter dut (
    .clk(clk), .reset(reset), .cfg_reg(cfg_reg), .din_user(din_user),
    .vld_user(vld_user), .ack_user(ack_user), .credit_return(credit_return),
    .stream_rdy(stream_rdy), .stream_out(stream_out), .resend(resend)
  );

  function automatic logic [N*CFGW-1:0] mk_cfg(logic [N-1:0] en);
    logic [N*CFGW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c[i*CFGW +: CFGW] = {en[i], 6'(i + 10), 4'(i + 1)};
    return c;
  endfunction

  function automatic logic [PB-1:0] exp_pkt(int ch, logic [D-1:0] d);
    return {1'b1, 6'(ch + 10), 4'(ch + 1), d};
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && stream_out[PB-1] === 1'b1 && stream_rdy === 1'b1) begin
      if (sb.size() == 0) check("unexpected_pkt", stream_out, 0);
      else check("pkt", stream_out, sb.pop_front());
    end
  end

  task automatic do_reset(logic [N-1:0] en);
    reset = 1'b0;
    sb.delete();
    vld_user = '0;
    credit_return = '0;
    resend = 1'b0;
    cfg_reg = mk_cfg(en);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    step();
  endtask

  task automatic write_stream(int ch, int n, logic [D-1:0] base);
    int sent;
    sent = 0;
    for (int guard = 0; guard < 600 && sent < n; guard++) begin
      vld_user[ch] = 1'b1;
      din_user[ch*D +: D] = base + D'(sent);
      @(negedge clk);
      if (ack_user[ch]) begin
        sb.push_back(exp_pkt(ch, base + D'(sent)));
        sent++;
      end
      step();
    end
    vld_user[ch] = 1'b0;
    check("write_done", sent, n);
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && stream_out[PB-1] == 1'b0) break;
      step();
    end
    check(tag, sb.size(), 0);
    check({tag, "_vld"}, stream_out[PB-1], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    reset = 1'b0; cfg_reg = mk_cfg('1); din_user = '0; vld_user = '0;
    credit_return = '0; stream_rdy = 1'b1; resend = 1'b0;
    #1;
    check("rst_stream_out", stream_out, 0);
    check("rst_ack", ack_user, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    step();
    check("ack_after_rst", ack_user, 7'h7F);
    check("credit_rst", dut.credit_q[0], 128);

    // single word on ch2: two-cycle latency
    vld_user[2] = 1'b1;
    din_user[2*D +: D] = 64'hA5;
    sb.push_back(exp_pkt(2, 64'hA5));
    step();
    vld_user[2] = 1'b0;
    check("t1_lat1", stream_out[PB-1], 0);
    step();
    check("t1_lat2", stream_out[PB-1], 0);
    step();
    check("t1_out", stream_out, exp_pkt(2, 64'hA5));
    check("t1_credit", dut.credit_q[2], 127);
    wait_idle("t1_idle");

    // round robin over ch0, ch3, ch5
    do_reset(7'b1010110);
    for (int w = 0; w < 3; w++) begin
      vld_user = 7'b0101001;
      din_user[0*D +: D] = 64'h200 + D'(w);
      din_user[3*D +: D] = 64'h230 + D'(w);
      din_user[5*D +: D] = 64'h250 + D'(w);
      sb.push_back(exp_pkt(0, 64'h200 + D'(w)));
      sb.push_back(exp_pkt(3, 64'h230 + D'(w)));
      sb.push_back(exp_pkt(5, 64'h250 + D'(w)));
      step();
    end
    vld_user = '0;
    step();
    step();
    cfg_reg = mk_cfg('1);
    for (int k = 0; k < 9; k++) begin
      step();
      check("t2_no_idle", stream_out[PB-1], 1);
    end
    wait_idle("t2_idle");

    // credit exhaustion and return on ch1
    do_reset('1);
    write_stream(1, 130, 64'h1000);
    for (int i = 0; i < 60 && dut.credit_q[1] != 0; i++) step();
    check("t3_credit0", dut.credit_q[1], 0);
    step();
    check("t3_stall_a", stream_out[PB-1], 0);
    step();
    check("t3_stall_b", stream_out[PB-1], 0);
    check("t3_left", sb.size(), 2);
    credit_return[1] = 1'b1;
    step();
    credit_return[1] = 1'b0;
    check("t3_credit64", dut.credit_q[1], 64);
    check("t3_not_yet", stream_out[PB-1], 0);
    step();
    check("t3_resume", stream_out, exp_pkt(1, 64'h1000 + 64'd128));
    wait_idle("t3_idle");
    check("t3_credit62", dut.credit_q[1], 62);

    // backpressure on ch6
    do_reset('1);
    stream_rdy = 1'b0;
    sent = 0;
    for (int guard = 0; guard < 20; guard++) begin
      vld_user[6] = 1'b1;
      din_user[6*D +: D] = 64'h6000 + D'(sent);
      @(negedge clk);
      if (!ack_user[6]) break;
      sb.push_back(exp_pkt(6, 64'h6000 + D'(sent)));
      sent++;
      step();
    end
    step();
    vld_user[6] = 1'b0;
    check("t4_accepted", sent, 9);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold", stream_out, exp_pkt(6, 64'h6000));
      check("t4_ack_low", ack_user[6], 0);
    end
    stream_rdy = 1'b1;
    wait_idle("t4_idle");
    check("t4_ack_back", ack_user[6], 1);

    // same-cycle grant and return saturates at 128
    do_reset('1);
    write_stream(4, 28, 64'h4000);
    wait_idle("t5_idle_a");
    check("t5_credit100", dut.credit_q[4], 100);
    vld_user[4] = 1'b1;
    din_user[4*D +: D] = 64'h4AAA;
    sb.push_back(exp_pkt(4, 64'h4AAA));
    step();
    vld_user[4] = 1'b0;
    step();
    credit_return[4] = 1'b1;
    step();
    credit_return[4] = 1'b0;
    check("t5_sat", dut.credit_q[4], 128);
    check("t5_out", stream_out, exp_pkt(4, 64'h4AAA));
    wait_idle("t5_idle_b");

    // resend of last packet
    do_reset('1);
    write_stream(0, 1, 64'h11);
    wait_idle("t6_idle_a");
    resend = 1'b1;
`ifdef STREAM_RESEND_EN
    sb.push_back(exp_pkt(0, 64'h11));
`endif
    step();
    resend = 1'b0;
    repeat (4) step();
    check("t6_left", sb.size(), 0);
    check("t6_credit", dut.credit_q[0], 127);

    // reset mid-packet
    write_stream(3, 1, 64'h33);
    for (int i = 0; i < 10 && stream_out[PB-1] == 1'b0; i++) step();
    check("t7_valid", stream_out[PB-1], 1);
    #2 reset = 1'b0;
    #1;
    check("t7_async_clear", stream_out, 0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) step();
    check("t7_discard", stream_out[PB-1], 0);
    check("t7_ack", ack_user, 7'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
